// File: rtl/tetris_pkg.sv
// Shared constants for the Tetris board renderer: board geometry,
// colour constants and the 7-entry piece palette.
package tetris_pkg;

    localparam int BOARD_COLS = 10;
    localparam int BOARD_ROWS = 20;
    localparam int IDX_W      = 3;
    localparam int ROW_W      = BOARD_COLS * IDX_W;

    localparam logic [23:0] RGB_OUTSIDE = 24'h000000;
    localparam logic [23:0] RGB_EMPTY   = 24'h101010;
    localparam logic [23:0] RGB_GRID    = 24'h202020;

    localparam logic [23:0] PAL_CYAN   = 24'h00FFFF;
    localparam logic [23:0] PAL_YELLOW = 24'hFFFF00;
    localparam logic [23:0] PAL_PURPLE = 24'h8000FF;
    localparam logic [23:0] PAL_GREEN  = 24'h00FF00;
    localparam logic [23:0] PAL_RED    = 24'hFF0000;
    localparam logic [23:0] PAL_BLUE   = 24'h0000FF;
    localparam logic [23:0] PAL_ORANGE = 24'hFF8000;

    // Index 0 is the empty cell colour.
    function automatic logic [23:0] palette(input logic [IDX_W-1:0] idx);
        logic [23:0] c;
        case (idx)
            3'd1:    c = PAL_CYAN;
            3'd2:    c = PAL_YELLOW;
            3'd3:    c = PAL_PURPLE;
            3'd4:    c = PAL_GREEN;
            3'd5:    c = PAL_RED;
            3'd6:    c = PAL_BLUE;
            3'd7:    c = PAL_ORANGE;
            default: c = RGB_EMPTY;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tetris_board_buf.sv
// Double-buffered playfield: game logic writes rows into shadow,
// commit copies shadow to active; active is read combinationally.
// Ports: clk, rst_n (sync, active-low), wr_en/wr_addr/wr_data row
// write, commit strobe, rd_row/rd_col cell address, rd_idx result.
module tetris_board_buf
    import tetris_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [ROW_W-1:0] wr_data,
    input  logic             commit,
    input  logic [4:0]       rd_row,
    input  logic [3:0]       rd_col,
    output logic [IDX_W-1:0] rd_idx
);

    logic [ROW_W-1:0] shadow [BOARD_ROWS];
    logic [ROW_W-1:0] active [BOARD_ROWS];
    logic [ROW_W-1:0] sel_row;

    // Commit copies the pre-write shadow, so a same-cycle write only
    // reaches active on the following commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < BOARD_ROWS; r++) begin
                shadow[r] <= '0;
                active[r] <= '0;
            end
        end else begin
            if (commit) begin
                for (int r = 0; r < BOARD_ROWS; r++) begin
                    active[r] <= shadow[r];
                end
            end
            if (wr_en && (wr_addr < 5'(BOARD_ROWS))) begin
                shadow[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        sel_row = '0;
        rd_idx  = '0;
        for (int r = 0; r < BOARD_ROWS; r++) begin
            if (rd_row == 5'(r)) sel_row = active[r];
        end
        for (int c = 0; c < BOARD_COLS; c++) begin
            if (rd_col == 4'(c)) rd_idx = sel_row[c*IDX_W +: IDX_W];
        end
    end

endmodule

// File: rtl/tetris_board_renderer.sv
// 3-stage pixel pipeline drawing a 10x20 Tetris board for hdmi_top.
// Ports: pixclk, rst_n (sync, active-low), counter_x/y, vde_in,
// hsync_in, vsync_in, row_wr_* board writes; R/G/B_data, VDE,
// hsync_out, vsync_out delayed 3 cycles. Option: GRID_LINES_EN.
module tetris_board_renderer
    import tetris_pkg::*;
#(
    parameter int BOARD_X0    = 240,
    parameter int BOARD_Y0    = 80,
    parameter int CELL_LOG2   = 4,
    parameter int COMMIT_LINE = 480
) (
    input  logic             pixclk,
    input  logic             rst_n,
    input  logic [9:0]       counter_x,
    input  logic [9:0]       counter_y,
    input  logic             vde_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             row_wr_en,
    input  logic [4:0]       row_wr_addr,
    input  logic [ROW_W-1:0] row_wr_data,
    output logic [7:0]       R_data,
    output logic [7:0]       G_data,
    output logic [7:0]       B_data,
    output logic             VDE,
    output logic             hsync_out,
    output logic             vsync_out
);

    localparam logic [9:0] X0   = 10'(BOARD_X0);
    localparam logic [9:0] Y0   = 10'(BOARD_Y0);
    localparam logic [9:0] W_PX = 10'(BOARD_COLS << CELL_LOG2);
    localparam logic [9:0] H_PX = 10'(BOARD_ROWS << CELL_LOG2);

    logic [9:0]       dx, dy;
    logic             commit;
    logic [IDX_W-1:0] cell_idx;

    logic             s1_vde, s1_hs, s1_vs, s1_in;
    logic [4:0]       s1_row;
    logic [3:0]       s1_col;
    logic             s2_vde, s2_hs, s2_vs, s2_in;
    logic [IDX_W-1:0] s2_idx;
    logic [23:0]      rgb;

    // Unsigned wrap makes pixels left/above the board look far away.
    assign dx     = counter_x - X0;
    assign dy     = counter_y - Y0;
    assign commit = (counter_x == '0) && (counter_y == 10'(COMMIT_LINE));

    tetris_board_buf u_buf (
        .clk     (pixclk),
        .rst_n   (rst_n),
        .wr_en   (row_wr_en),
        .wr_addr (row_wr_addr),
        .wr_data (row_wr_data),
        .commit  (commit),
        .rd_row  (s1_row),
        .rd_col  (s1_col),
        .rd_idx  (cell_idx)
    );

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            s1_vde <= 1'b0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_in  <= 1'b0;
            s1_row <= '0;
            s1_col <= '0;
            s2_vde <= 1'b0;
            s2_hs  <= 1'b0;
            s2_vs  <= 1'b0;
            s2_in  <= 1'b0;
            s2_idx <= '0;
        end else begin
            s1_vde <= vde_in;
            s1_hs  <= hsync_in;
            s1_vs  <= vsync_in;
            s1_in  <= (dx < W_PX) && (dy < H_PX);
            s1_row <= 5'(dy >> CELL_LOG2);
            s1_col <= 4'(dx >> CELL_LOG2);
            s2_vde <= s1_vde;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_in  <= s1_in;
            s2_idx <= s1_in ? cell_idx : '0;
        end
    end

`ifdef GRID_LINES_EN
    logic s1_edge, s2_edge;

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            s1_edge <= 1'b0;
            s2_edge <= 1'b0;
        end else begin
            s1_edge <= (counter_x[CELL_LOG2-1:0] == '0) ||
                       (counter_y[CELL_LOG2-1:0] == '0);
            s2_edge <= s1_edge;
        end
    end
`endif

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            rgb       <= '0;
            VDE       <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            VDE       <= s2_vde;
            hsync_out <= s2_hs;
            vsync_out <= s2_vs;
            if (!s2_vde)
                rgb <= '0;
            else if (!s2_in)
                rgb <= RGB_OUTSIDE;
            else if (s2_idx == '0)
                rgb <= RGB_EMPTY;
`ifdef GRID_LINES_EN
            else if (s2_edge)
                rgb <= RGB_GRID;
`endif
            else
                rgb <= palette(s2_idx);
        end
    end

    assign R_data = rgb[23:16];
    assign G_data = rgb[15:8];
    assign B_data = rgb[7:0];

endmodule

// File: tb/tb_tetris_board_renderer.sv
// Self-checking bench for tetris_board_renderer: cycle-by-cycle
// comparison against a board-level model plus literal pixel checks.
module tb_tetris_board_renderer;

    logic        pixclk = 1'b0;
    logic        rst_n;
    logic [9:0]  counter_x, counter_y;
    logic        vde_in, hsync_in, vsync_in;
    logic        row_wr_en;
    logic [4:0]  row_wr_addr;
    logic [29:0] row_wr_data;
    logic [7:0]  R_data, G_data, B_data;
    logic        VDE, hsync_out, vsync_out;

    int tests = 0;
    int fails = 0;

    always #5 pixclk = ~pixclk;

    tetris_board_renderer dut (
        .pixclk      (pixclk),
        .rst_n       (rst_n),
        .counter_x   (counter_x),
        .counter_y   (counter_y),
        .vde_in      (vde_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .row_wr_en   (row_wr_en),
        .row_wr_addr (row_wr_addr),
        .row_wr_data (row_wr_data),
        .R_data      (R_data),
        .G_data      (G_data),
        .B_data      (B_data),
        .VDE         (VDE),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out)
    );

    // ---------------- model ----------------
    int m_shadow [20][10];
    int m_active [20][10];

    typedef struct {
        logic [23:0] rgb;
        logic        vde, hs, vs;
    } exp_t;

    exp_t e1, e2, eo;
    bit   started = 0;

    function automatic logic [23:0] pal(int idx);
        case (idx)
            1: return 24'h00FFFF;
            2: return 24'hFFFF00;
            3: return 24'h8000FF;
            4: return 24'h00FF00;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            7: return 24'hFF8000;
            default: return 24'h101010;
        endcase
    endfunction

    function automatic exp_t pixel(int x, int y, bit v, bit hs, bit vs);
        exp_t e;
        int dx, dy, idx;
        e.vde = v; e.hs = hs; e.vs = vs; e.rgb = 24'h0;
        dx = x - 240;
        dy = y - 80;
        if (v && dx >= 0 && dx < 160 && dy >= 0 && dy < 320) begin
            idx = m_active[dy/16][dx/16];
            if (idx == 0) e.rgb = 24'h101010;
`ifdef GRID_LINES_EN
            else if (x % 16 == 0 || y % 16 == 0) e.rgb = 24'h202020;
`endif
            else e.rgb = pal(idx);
        end
        return e;
    endfunction

    always begin
        @(posedge pixclk);
        #1;
        if (!rst_n) begin
            started = 1;
            for (int r = 0; r < 20; r++)
                for (int c = 0; c < 10; c++) begin
                    m_shadow[r][c] = 0;
                    m_active[r][c] = 0;
                end
            e1 = '{24'h0, 1'b0, 1'b0, 1'b0};
            e2 = e1;
            eo = e1;
        end else if (started) begin
            if (counter_x == 0 && counter_y == 480)
                m_active = m_shadow;
            if (row_wr_en && row_wr_addr < 20)
                for (int c = 0; c < 10; c++)
                    m_shadow[row_wr_addr][c] = int'((row_wr_data >> (3*c)) & 30'h7);
            eo = e2;
            e2 = e1;
            e1 = pixel(counter_x, counter_y, vde_in, hsync_in, vsync_in);
        end
        if (started) begin
            tests++;
            if ({R_data, G_data, B_data} !== eo.rgb || VDE !== eo.vde ||
                hsync_out !== eo.hs || vsync_out !== eo.vs) begin
                fails++;
                $display("FAIL model t=%0t got rgb=%h vde=%b hs=%b vs=%b want rgb=%h vde=%b hs=%b vs=%b",
                         $time, {R_data, G_data, B_data}, VDE, hsync_out, vsync_out,
                         eo.rgb, eo.vde, eo.hs, eo.vs);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic idle();
        counter_x = 10'd600; counter_y = 10'd500;
        vde_in = 0; hsync_in = 0; vsync_in = 0;
        row_wr_en = 0; row_wr_addr = 0; row_wr_data = 0;
    endtask

    task automatic pix(string name, int x, int y, bit v,
                       logic [23:0] want, bit want_vde);
        @(negedge pixclk);
        counter_x = 10'(x); counter_y = 10'(y); vde_in = v;
        @(negedge pixclk);
        idle();
        @(posedge pixclk);
        @(posedge pixclk);
        #2;
        check(name, {8'h0, R_data, G_data, B_data}, {8'h0, want});
        check({name, "_vde"}, {31'h0, VDE}, {31'h0, want_vde});
    endtask

    task automatic wr(int addr, logic [29:0] data);
        @(negedge pixclk);
        row_wr_en = 1; row_wr_addr = 5'(addr); row_wr_data = data;
        @(negedge pixclk);
        idle();
    endtask

    task automatic commit(bit with_wr, int addr, logic [29:0] data);
        @(negedge pixclk);
        counter_x = 10'd0; counter_y = 10'd480;
        if (with_wr) begin
            row_wr_en = 1; row_wr_addr = 5'(addr); row_wr_data = data;
        end
        @(negedge pixclk);
        idle();
    endtask

    task automatic scan_board();
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) begin
                @(negedge pixclk);
                counter_x = 10'(240 + 16*c + 8);
                counter_y = 10'(80 + 16*r + 8);
                vde_in = 1;
            end
        @(negedge pixclk);
        idle();
        repeat (3) @(negedge pixclk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle();
        rst_n = 0;
        repeat (2) begin
            @(negedge pixclk);
            counter_x = 10'($urandom_range(0, 1023));
            counter_y = 10'($urandom_range(0, 1023));
            vde_in = 1; hsync_in = 1; vsync_in = 1;
        end
        @(negedge pixclk);
        check("reset_rgb", {8'h0, R_data, G_data, B_data}, 32'h0);
        check("reset_sync", {29'h0, VDE, hsync_out, vsync_out}, 32'h0);
        idle();
        rst_n = 1;
        repeat (3) @(negedge pixclk);

        scan_board();
        pix("empty_after_reset", 248, 88, 1, 24'h101010, 1);

        wr(0, 30'h1);
        commit(0, 0, 0);
        pix("cyan_cell00", 240, 80, 1, 24'h00FFFF, 1);
        pix("empty_cell10", 256, 80, 1, 24'h101010, 1);

        wr(19, 30'(5) << 27);
        pix("pre_commit", 399, 399, 1, 24'h101010, 1);
        commit(0, 0, 0);
`ifdef GRID_LINES_EN
        pix("red_corner", 399, 399, 1, 24'hFF0000, 1);
`else
        pix("red_corner", 399, 399, 1, 24'hFF0000, 1);
`endif
        pix("right_outside", 400, 399, 1, 24'h000000, 1);
        pix("left_outside", 239, 100, 1, 24'h000000, 1);
        pix("above_outside", 300, 79, 1, 24'h000000, 1);
        pix("below_outside", 300, 400, 1, 24'h000000, 1);

        wr(25, 30'h3FFFFFFF);
        commit(0, 0, 0);
        scan_board();
        pix("bad_addr_row5", 248, 168, 1, 24'h101010, 1);

        commit(1, 10, 30'h3);
        pix("same_cycle_wr", 248, 248, 1, 24'h101010, 1);
        commit(0, 0, 0);
        pix("after_2nd_commit", 248, 248, 1, 24'h8000FF, 1);

        pix("vde_low", 240, 80, 0, 24'h000000, 0);

        @(negedge pixclk);
        hsync_in = 1; vsync_in = 1;
        @(negedge pixclk);
        idle();
        @(posedge pixclk); #2;
        check("sync_lat2", {30'h0, hsync_out, vsync_out}, 32'h0);
        @(posedge pixclk); #2;
        check("sync_lat3", {30'h0, hsync_out, vsync_out}, 32'h3);
        @(posedge pixclk); #2;
        check("sync_after", {30'h0, hsync_out, vsync_out}, 32'h0);

        wr(0, 30'h2);
        commit(0, 0, 0);
`ifdef GRID_LINES_EN
        pix("grid_edge", 240, 85, 1, 24'h202020, 1);
`else
        pix("grid_edge", 240, 85, 1, 24'hFFFF00, 1);
`endif
        pix("grid_inner", 241, 85, 1, 24'hFFFF00, 1);
        pix("grid_empty", 256, 85, 1, 24'h101010, 1);

        for (int i = 0; i < 6; i++) begin
            @(negedge pixclk);
            counter_x = 10'(241 + i); counter_y = 10'd85; vde_in = 1;
            if (i == 3) rst_n = 0;
            else rst_n = 1;
        end
        @(negedge pixclk);
        rst_n = 1;
        idle();
        repeat (4) @(negedge pixclk);
        pix("post_reset_clear", 241, 85, 1, 24'h101010, 1);

        repeat (2) @(negedge pixclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
